// File: rtl/vga_rx_tile_decoder.sv
// VGA receiver: recovers position from hsync/vsync, checks line/frame timing,
// locks, and rebuilds the 8x8 tile-state word from tile-centre green samples.
module vga_rx_tile_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_BP     = 48,
  parameter int V_BP     = 33,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int TILE_W   = 50,
  parameter int TILE_H   = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  red_in,
  input  logic [2:0]  green_in,
  input  logic [2:0]  blue_in,
  output logic        locked,
  output logic [9:0]  cur_x,
  output logic [9:0]  cur_y,
  output logic        pix_active,
  output logic [63:0] tiles,
  output logic        tiles_valid,
  output logic        err_line,
  output logic        err_frame
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;
  state_t state, state_next;

  logic        hsync_r1, vsync_r1, hsync_r2, vsync_r2;
  logic [2:0]  red_r1, green_r1, blue_r1;
  logic        rb_unused;
  logic        h_rise, v_rise;
  logic [9:0]  h_cnt, v_cnt;
  logic [10:0] h_cnt_inc, v_cnt_eff;
  logic        line_bad, frame_bad, frame_err, frame_dirty, commit;
  logic [63:0] shadow;
  logic        col_hit, row_hit, samp_hit;
  logic [2:0]  col_idx, row_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      hsync_r1 <= 1'b0;
      vsync_r1 <= 1'b0;
      hsync_r2 <= 1'b0;
      vsync_r2 <= 1'b0;
      red_r1   <= 3'd0;
      green_r1 <= 3'd0;
      blue_r1  <= 3'd0;
    end else begin
      hsync_r1 <= hsync_in;
      vsync_r1 <= vsync_in;
      hsync_r2 <= hsync_r1;
      vsync_r2 <= vsync_r1;
      red_r1   <= red_in;
      green_r1 <= green_in;
      blue_r1  <= blue_in;
    end
  end

  // Red and blue are captured for observation only; tile state is green.
  assign rb_unused = ^{red_r1, blue_r1};

  assign h_rise    = hsync_r1 & ~hsync_r2;
  assign v_rise    = vsync_r1 & ~vsync_r2;
  assign h_cnt_inc = {1'b0, h_cnt} + 11'd1;
  // A line ending on the vsync edge still counts toward the frame.
  assign v_cnt_eff = {1'b0, v_cnt} + {10'd0, h_rise};
  assign line_bad  = h_rise && (state != SEARCH) && (h_cnt_inc != 11'(H_TOTAL));
  assign frame_bad = v_rise && (state != SEARCH) && (v_cnt_eff != 11'(V_TOTAL));
  assign frame_dirty = frame_err | line_bad | frame_bad;
  assign commit    = (state == LOCKED) && v_rise && !frame_dirty;

  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt     <= 10'd0;
      v_cnt     <= 10'd0;
      frame_err <= 1'b0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      err_line  <= line_bad;
      err_frame <= frame_bad;
      frame_err <= v_rise ? 1'b0 : (frame_err | line_bad);
      if (v_rise && state == SEARCH) begin
        h_cnt <= 10'd0;
        v_cnt <= 10'd0;
      end else begin
        if (h_rise)
          h_cnt <= 10'd0;
        else if (h_cnt != 10'd1023)
          h_cnt <= h_cnt + 10'd1;
        if (v_rise)
          v_cnt <= 10'd0;
        else if (h_rise && v_cnt != 10'd1023)
          v_cnt <= v_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    pix_active = (h_cnt >= 10'(H_BP)) && (h_cnt < 10'(H_BP + H_ACTIVE)) &&
                 (v_cnt >= 10'(V_BP)) && (v_cnt < 10'(V_BP + V_ACTIVE));
    cur_x = pix_active ? (h_cnt - 10'(H_BP)) : 10'd0;
    cur_y = pix_active ? (v_cnt - 10'(V_BP)) : 10'd0;
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= SEARCH;
    else
      state <= state_next;
  end

  // Errors seen while locked act one cycle later, after their pulse is out.
  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (v_rise) state_next = MEASURE;
      MEASURE: if (v_rise && !frame_dirty) state_next = LOCKED;
      LOCKED:  if (err_line || err_frame) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_comb begin
    col_hit = 1'b0;
    row_hit = 1'b0;
    col_idx = 3'd0;
    row_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cur_x == 10'(i * TILE_W + TILE_W / 2)) begin
        col_hit = 1'b1;
        col_idx = 3'(i);
      end
      if (cur_y == 10'(i * TILE_H + TILE_H / 2)) begin
        row_hit = 1'b1;
        row_idx = 3'(i);
      end
    end
    samp_hit = pix_active & col_hit & row_hit;
  end

  // tiles_valid is a one-cycle strobe that coincides with the new tiles
  // value; there is no back-pressure, so a consumer must take it then.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow      <= 64'd0;
      tiles       <= 64'd0;
      tiles_valid <= 1'b0;
    end else begin
      tiles_valid <= 1'b0;
      if (state == LOCKED && (err_line || err_frame))
        shadow <= 64'd0;
      else if (state == LOCKED && samp_hit)
        shadow[{row_idx, col_idx}] <= |green_r1;
      if (commit) begin
        tiles       <= shadow;
        tiles_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_tile_decoder.sv
// Bench for vga_rx_tile_decoder: a reduced raster drives frame-level vectors
// and every cycle's recovered position is compared with the pixel driven two cycles earlier.
module tb_vga_rx_tile_decoder;

  localparam int HT  = 42;
  localparam int VT  = 37;
  localparam int HBP = 4;
  localparam int VBP = 2;
  localparam int HA  = 32;
  localparam int VA  = 32;
  localparam int TW  = 4;
  localparam int TH  = 4;
  localparam int NF  = 19;
  localparam logic [63:0] NOMINAL = (64'd1 << 0) | (64'd1 << 29) | (64'd1 << 63);

  logic        clock, reset, hsync_in, vsync_in;
  logic [2:0]  red_in, green_in, blue_in;
  logic        locked, pix_active, tiles_valid, err_line, err_frame;
  logic [9:0]  cur_x, cur_y;
  logic [63:0] tiles;

  vga_rx_tile_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_BP(HBP), .V_BP(VBP),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .TILE_W(TW), .TILE_H(TH)
  ) dut (
    .clock(clock), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .locked(locked), .cur_x(cur_x), .cur_y(cur_y), .pix_active(pix_active),
    .tiles(tiles), .tiles_valid(tiles_valid), .err_line(err_line), .err_frame(err_frame)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int n_lines;
    int short_line;
    int rst_line;
    bit rand_pat;
    int exp_eline;
    int exp_eframe;
    int exp_valid;
    bit exp_locked;
  } frame_vec_t;

  typedef struct {
    int l;
    int p;
    bit known;
  } pos_t;

  frame_vec_t  vecs[NF];
  logic [63:0] pats[NF];
  logic [63:0] exp_q[$];
  logic [63:0] exp_hold;
  pos_t        hist[$];
  int n_checks = 0;
  int n_errors = 0;
  int cnt_eline, cnt_eframe, cnt_valid;
  bit sync_seen, rst_check, err_seen_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic tile_on(input logic [63:0] pat, input int l, input int p);
    int x = p - HBP;
    int y = l - VBP;
    if (x < 0 || x >= 8 * TW || y < 0 || y >= 8 * TH) return 1'b0;
    return pat[(y / TH) * 8 + x / TW];
  endfunction

  task automatic tick(input logic hs, input logic vs, input logic [63:0] pat,
                      input int l, input int p, input bit rst);
    pos_t e;
    logic [20:0] exp_pos;
    @(posedge clock);
    #1;
    hsync_in = hs;
    vsync_in = vs;
    reset    = rst;
    if (tile_on(pat, l, p)) begin
      green_in = 3'($urandom_range(1, 7));
      red_in   = 3'($urandom_range(0, 7));
      blue_in  = 3'd0;
    end else begin
      green_in = 3'd0;
      red_in   = 3'($urandom_range(0, 7));
      blue_in  = 3'($urandom_range(1, 7));
    end
    if (rst) begin
      sync_seen = 1'b0;
      hist.delete();
    end
    if (l == 0 && p == 0 && !rst) sync_seen = 1'b1;
    hist.push_back('{l, p, sync_seen && !rst});
    @(negedge clock);
    if (rst_check) begin
      check("reset_locked", {63'd0, locked}, 64'd0);
      check("reset_tiles", tiles, 64'd0);
      check("reset_tiles_valid", {63'd0, tiles_valid}, 64'd0);
      rst_check = 1'b0;
    end
    if (rst) rst_check = 1'b1;
    if (err_seen_prev) check("locked_after_err", {63'd0, locked}, 64'd0);
    err_seen_prev = err_line | err_frame;
    cnt_eline  += int'(err_line);
    cnt_eframe += int'(err_frame);
    cnt_valid  += int'(tiles_valid);
    if (tiles_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tiles_commit: got unexpected tiles_valid with tiles %h", tiles);
      end else begin
        check("tiles_commit", tiles, exp_q.pop_front());
      end
    end
    if (hist.size() > 2) begin
      e = hist.pop_front();
      if (e.known) begin
        if (e.p >= HBP && e.p < HBP + HA && e.l >= VBP && e.l < VBP + VA)
          exp_pos = {1'b1, 10'(e.l - VBP), 10'(e.p - HBP)};
        else
          exp_pos = 21'd0;
        check($sformatf("position l%0d p%0d", e.l, e.p),
              {43'd0, pix_active, cur_y, cur_x}, {43'd0, exp_pos});
      end
    end
  endtask

  task automatic run_frame(input int k);
    frame_vec_t v;
    int len;
    v = vecs[k];
    pats[k] = v.rand_pat ? {$urandom, $urandom} : NOMINAL;
    if (v.exp_valid > 0 && k > 0) begin
      exp_q.push_back(pats[k - 1]);
      exp_hold = pats[k - 1];
    end
    cnt_eline = 0;
    cnt_eframe = 0;
    cnt_valid = 0;
    for (int l = 0; l < v.n_lines; l++) begin
      len = (l == v.short_line) ? HT - 1 : HT;
      for (int p = 0; p < len; p++)
        tick(p < len - 4, l < v.n_lines - 2, pats[k], l, p, (l == v.rst_line) && (p == len - 2));
    end
    if (v.rst_line >= 0) exp_hold = 64'd0;
    exp_q.delete();
    check($sformatf("f%0d err_line_count", k), 64'(cnt_eline), 64'(v.exp_eline));
    check($sformatf("f%0d err_frame_count", k), 64'(cnt_eframe), 64'(v.exp_eframe));
    check($sformatf("f%0d tiles_valid_count", k), 64'(cnt_valid), 64'(v.exp_valid));
    check($sformatf("f%0d locked_end", k), {63'd0, locked}, {63'd0, v.exp_locked});
    check($sformatf("f%0d tiles_hold", k), tiles, exp_hold);
  endtask

  initial begin
    reset = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    red_in = 3'd0;
    green_in = 3'd0;
    blue_in = 3'd0;
    sync_seen = 1'b0;
    rst_check = 1'b0;
    err_seen_prev = 1'b0;
    exp_hold = 64'd0;
    //          lines   short rst     rand  eline eframe valid locked
    vecs[0]  = '{VT,     -1, -1,     1'b1, 0, 0, 0, 1'b0};
    vecs[1]  = '{VT,     -1, -1,     1'b0, 0, 0, 0, 1'b1};
    vecs[2]  = '{VT,     -1, -1,     1'b1, 0, 0, 1, 1'b1};
    vecs[3]  = '{VT,     -1, -1,     1'b1, 0, 0, 1, 1'b1};
    vecs[4]  = '{VT,      5, -1,     1'b1, 1, 0, 1, 1'b0};
    vecs[5]  = '{VT,     -1, -1,     1'b1, 0, 0, 0, 1'b0};
    vecs[6]  = '{VT,     -1, -1,     1'b1, 0, 0, 0, 1'b1};
    vecs[7]  = '{VT,     -1, -1,     1'b1, 0, 0, 1, 1'b1};
    vecs[8]  = '{VT - 1, -1, -1,     1'b1, 0, 0, 1, 1'b1};
    vecs[9]  = '{VT,     -1, -1,     1'b1, 0, 1, 0, 1'b0};
    vecs[10] = '{VT - 1, -1, -1,     1'b1, 0, 0, 0, 1'b0};
    vecs[11] = '{VT,     -1, -1,     1'b1, 0, 1, 0, 1'b0};
    vecs[12] = '{VT,     -1, -1,     1'b1, 0, 0, 0, 1'b1};
    vecs[13] = '{VT,     -1, -1,     1'b1, 0, 0, 1, 1'b1};
    vecs[14] = '{VT,     -1, VT - 2, 1'b1, 0, 0, 1, 1'b0};
    vecs[15] = '{VT,     -1, -1,     1'b1, 0, 0, 0, 1'b0};
    vecs[16] = '{VT,     -1, -1,     1'b1, 0, 0, 0, 1'b1};
    vecs[17] = '{VT,     -1, -1,     1'b1, 0, 0, 1, 1'b1};
    vecs[18] = '{VT,     -1, -1,     1'b1, 0, 0, 1, 1'b1};

    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 64'd0, -1, -1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 64'd0, -1, -1, 1'b0);
    check("idle_locked", {63'd0, locked}, 64'd0);
    check("idle_pix_active", {63'd0, pix_active}, 64'd0);
    check("idle_cur_x", {54'd0, cur_x}, 64'd0);
    check("idle_cur_y", {54'd0, cur_y}, 64'd0);
    check("idle_tiles", tiles, 64'd0);
    check("idle_tiles_valid", {63'd0, tiles_valid}, 64'd0);
    check("idle_err_line", {63'd0, err_line}, 64'd0);
    check("idle_err_frame", {63'd0, err_frame}, 64'd0);

    for (int k = 0; k < NF; k++) run_frame(k);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
